// File: rtl/bot_port_master.sv
// bot_port_master: interrupt-driven port-bus master for a robot controller.
//
// When the responder raises an interrupt edge (and enable is high), the master
// acknowledges it, reads LOCX/LOCY/BOTINFO/SENSORS over the port bus, then
// writes a motor command. The command is forced to 8'h00 when any STOP_MASK
// bit is set in the captured sensors value. Edges arriving while the master is
// busy are collapsed into a single pending request, and each collapsed extra
// edge is counted in miss_cnt.
//
// Configuration macro: BOT_PORT_MASTER_LED_MIRROR_EN
//   defined   - after the motor write, the captured sensors value is also
//               written to PORT_LEDS
//   undefined - the motor write is followed directly by DONE
//
// Ports:
//   clk, reset                  system clock; synchronous active-high reset
//   port_id, out_port           bus address and write data
//   in_port                     bus read data
//   write_strobe, read_strobe   one-cycle transfer strobes
//   k_write_strobe              constant-write strobe, tied low
//   interrupt, interrupt_ack    level request / one-cycle acknowledge
//   enable                      permits new transactions to start
//   cmd_in                      motor command used when not stopped
//   locx, locy, botinfo, sensors  last captured register values
//   busy, done                  not-idle flag / end-of-transaction pulse
//   miss_cnt                    saturating count of collapsed interrupt edges
module bot_port_master #(
   parameter logic [7:0] PORT_MOTCTL  = 8'h09,
   parameter logic [7:0] PORT_LOCX    = 8'h0A,
   parameter logic [7:0] PORT_LOCY    = 8'h0B,
   parameter logic [7:0] PORT_BOTINFO = 8'h0C,
   parameter logic [7:0] PORT_SENSORS = 8'h0D,
   parameter logic [7:0] PORT_LEDS    = 8'h02,
   parameter logic [7:0] STOP_MASK    = 8'h07
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] port_id,
   output logic [7:0] out_port,
   input  logic [7:0] in_port,
   output logic       write_strobe,
   output logic       read_strobe,
   output logic       k_write_strobe,
   input  logic       interrupt,
   output logic       interrupt_ack,
   input  logic       enable,
   input  logic [7:0] cmd_in,
   output logic [7:0] locx,
   output logic [7:0] locy,
   output logic [7:0] botinfo,
   output logic [7:0] sensors,
   output logic       busy,
   output logic       done,
   output logic [7:0] miss_cnt
);

   typedef enum logic [3:0] {
      StIdle,
      StAck,
      StRdSetup,
      StRdStrobe,
      StRdCapt,
      StWrSetup,
      StWrStrobe,
`ifdef BOT_PORT_MASTER_LED_MIRROR_EN
      StLedSetup,
      StLedStrobe,
`endif
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] port_id_q, port_id_d;
   logic [7:0] out_port_q, out_port_d;
   logic [7:0] locx_q, locx_d;
   logic [7:0] locy_q, locy_d;
   logic [7:0] botinfo_q, botinfo_d;
   logic [7:0] sensors_q, sensors_d;
   logic [7:0] miss_q, miss_d;
   logic       pending_q, pending_d;
   logic       int_q;

   logic       irq_event;
   logic       start;
   logic [7:0] motor_val;

   function automatic logic [7:0] rd_addr(input logic [1:0] idx);
      logic [7:0] addr;
      unique case (idx)
         2'd0:    addr = PORT_LOCX;
         2'd1:    addr = PORT_LOCY;
         2'd2:    addr = PORT_BOTINFO;
         default: addr = PORT_SENSORS;
      endcase
      return addr;
   endfunction

   assign irq_event = interrupt & ~int_q;
   assign start     = (state_q == StIdle) && enable && (irq_event || pending_q);
   // sensors_q is already updated by WR_SETUP, so the stop decision sees this
   // transaction's reading; cmd_in is taken live in that cycle.
   assign motor_val = ((sensors_q & STOP_MASK) != 8'h00) ? 8'h00 : cmd_in;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      port_id_d  = port_id_q;
      out_port_d = out_port_q;
      locx_d     = locx_q;
      locy_d     = locy_q;
      botinfo_d  = botinfo_q;
      sensors_d  = sensors_q;
      miss_d     = miss_q;
      pending_d  = pending_q;

      // Any edge that does not start a transaction right now is remembered;
      // a second one before service is counted as lost.
      if (start) begin
         pending_d = 1'b0;
      end else if (irq_event) begin
         pending_d = 1'b1;
         if (pending_q && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StAck;
         end
         StAck: begin
            state_d   = StRdSetup;
            idx_d     = 2'd0;
            port_id_d = PORT_LOCX;
         end
         StRdSetup:  state_d = StRdStrobe;
         StRdStrobe: state_d = StRdCapt;
         StRdCapt: begin
            unique case (idx_q)
               2'd0:    locx_d    = in_port;
               2'd1:    locy_d    = in_port;
               2'd2:    botinfo_d = in_port;
               default: sensors_d = in_port;
            endcase
            if (idx_q == 2'd3) begin
               state_d   = StWrSetup;
               port_id_d = PORT_MOTCTL;
            end else begin
               state_d   = StRdSetup;
               idx_d     = idx_q + 2'd1;
               port_id_d = rd_addr(idx_q + 2'd1);
            end
         end
         StWrSetup: begin
            state_d    = StWrStrobe;
            out_port_d = motor_val;
         end
         StWrStrobe: begin
`ifdef BOT_PORT_MASTER_LED_MIRROR_EN
            state_d    = StLedSetup;
            port_id_d  = PORT_LEDS;
            out_port_d = sensors_q;
`else
            state_d    = StDone;
`endif
         end
`ifdef BOT_PORT_MASTER_LED_MIRROR_EN
         StLedSetup:  state_d = StLedStrobe;
         StLedStrobe: state_d = StDone;
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= 2'd0;
         port_id_q  <= 8'h00;
         out_port_q <= 8'h00;
         locx_q     <= 8'h00;
         locy_q     <= 8'h00;
         botinfo_q  <= 8'h00;
         sensors_q  <= 8'h00;
         miss_q     <= 8'h00;
         pending_q  <= 1'b0;
         int_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         port_id_q  <= port_id_d;
         out_port_q <= out_port_d;
         locx_q     <= locx_d;
         locy_q     <= locy_d;
         botinfo_q  <= botinfo_d;
         sensors_q  <= sensors_d;
         miss_q     <= miss_d;
         pending_q  <= pending_d;
         int_q      <= interrupt;
      end
   end

   assign port_id        = port_id_q;
   // In WR_SETUP the motor value is shown live; it is then held from out_port_q.
   assign out_port       = (state_q == StWrSetup) ? motor_val : out_port_q;
   assign read_strobe    = (state_q == StRdStrobe);
`ifdef BOT_PORT_MASTER_LED_MIRROR_EN
   assign write_strobe   = (state_q == StWrStrobe) || (state_q == StLedStrobe);
`else
   assign write_strobe   = (state_q == StWrStrobe);
`endif
   assign k_write_strobe = 1'b0;
   assign interrupt_ack  = (state_q == StAck);
   assign busy           = (state_q != StIdle);
   assign done           = (state_q == StDone);
   assign locx           = locx_q;
   assign locy           = locy_q;
   assign botinfo        = botinfo_q;
   assign sensors        = sensors_q;
   assign miss_cnt       = miss_q;

endmodule

// File: tb/tb_bot_port_master.sv
// Self-checking bench for bot_port_master. Expected port writes are queued
// when a transaction is launched and checked by a monitor on every strobe.
module tb_bot_port_master;

`ifdef BOT_PORT_MASTER_LED_MIRROR_EN
   localparam int DoneCyc = 18;
   localparam bit LedEn   = 1'b1;
`else
   localparam int DoneCyc = 16;
   localparam bit LedEn   = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id, out_port, in_port;
   logic       write_strobe, read_strobe, k_write_strobe;
   logic       interrupt, interrupt_ack, enable;
   logic [7:0] cmd_in;
   logic [7:0] locx, locy, botinfo, sensors, miss_cnt;
   logic       busy, done;

   typedef struct {
      logic [7:0] port;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] resp [4];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   bot_port_master dut (
      .clk           (clk),
      .reset         (reset),
      .port_id       (port_id),
      .out_port      (out_port),
      .in_port       (in_port),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .k_write_strobe(k_write_strobe),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .enable        (enable),
      .cmd_in        (cmd_in),
      .locx          (locx),
      .locy          (locy),
      .botinfo       (botinfo),
      .sensors       (sensors),
      .busy          (busy),
      .done          (done),
      .miss_cnt      (miss_cnt)
   );

   // Responder: returns the table entry for the addressed read register.
   always_comb begin
      in_port = 8'h00;
      case (port_id)
         8'h0A:   in_port = resp[0];
         8'h0B:   in_port = resp[1];
         8'h0C:   in_port = resp[2];
         8'h0D:   in_port = resp[3];
         default: in_port = 8'h00;
      endcase
   end

   // Write monitor / scoreboard consumer.
   always @(negedge clk) begin
      n_checks++;
      if (write_strobe && read_strobe) begin
         n_fail++;
         $display("FAIL strobe_excl: write_strobe=%b read_strobe=%b, required not both 1",
                  write_strobe, read_strobe);
      end
      n_checks++;
      if (k_write_strobe !== 1'b0) begin
         n_fail++;
         $display("FAIL k_write_strobe: got %b, required 0", k_write_strobe);
      end
      if (write_strobe === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: port %h data %h, required no write", port_id,
                     out_port);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            if (port_id !== w.port || out_port !== w.data) begin
               n_fail++;
               $display("FAIL write: got port %h data %h, required port %h data %h", port_id,
                        out_port, w.port, w.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_txn(input logic [7:0] sens, input logic [7:0] cmd);
      wr_t w;
      w.port = 8'h09;
      w.data = ((sens & 8'h07) != 8'h00) ? 8'h00 : cmd;
      exp_q.push_back(w);
      if (LedEn) begin
         w.port = 8'h02;
         w.data = sens;
         exp_q.push_back(w);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({busy, done, interrupt_ack, write_strobe, read_strobe} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 00000",
                  {busy, done, interrupt_ack, write_strobe, read_strobe});
      end
      n_checks++;
      if ({port_id, out_port} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_bus: got %h, required 0000", {port_id, out_port});
      end
      n_checks++;
      if ({locx, locy, botinfo, sensors, miss_cnt} !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_regs: got %h, required 0", {locx, locy, botinfo, sensors, miss_cnt});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_txn(input string name, input logic [7:0] sens, input logic [7:0] cmd);
      logic exp_ack, exp_ws, exp_rs, exp_done, exp_busy;
      resp[0] = 8'h11;
      resp[1] = 8'h22;
      resp[2] = 8'h33;
      resp[3] = sens;
      cmd_in  = cmd;
      push_txn(sens, cmd);
      interrupt = 1'b1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle0: busy got %b, required 0", name, busy);
      end
      for (int c = 1; c <= DoneCyc + 1; c++) begin
         tick();
         if (c == 2) interrupt = 1'b0;
         exp_ack  = (c == 1);
         exp_ws   = (c == 15) || (LedEn && c == 17);
         exp_rs   = (c == 3) || (c == 6) || (c == 9) || (c == 12);
         exp_done = (c == DoneCyc);
         exp_busy = (c <= DoneCyc);
         n_checks++;
         if ({interrupt_ack, write_strobe, read_strobe, done, busy} !==
             {exp_ack, exp_ws, exp_rs, exp_done, exp_busy}) begin
            n_fail++;
            $display("FAIL %s_cyc%0d: ack/ws/rs/done/busy got %b, required %b", name, c,
                     {interrupt_ack, write_strobe, read_strobe, done, busy},
                     {exp_ack, exp_ws, exp_rs, exp_done, exp_busy});
         end
      end
      n_checks++;
      if ({locx, locy, botinfo, sensors} !== {8'h11, 8'h22, 8'h33, sens}) begin
         n_fail++;
         $display("FAIL %s_capture: got %h, required %h", name, {locx, locy, botinfo, sensors},
                  {8'h11, 8'h22, 8'h33, sens});
      end
   endtask

   task automatic test_pending();
      logic [7:0] base;
      logic       exp_ack, exp_done;
      resp[3] = 8'h40;
      cmd_in  = 8'h3C;
      base    = miss_cnt;
      push_txn(8'h40, 8'h3C);
      push_txn(8'h40, 8'h3C);
      interrupt = 1'b1;
      for (int c = 1; c <= 2 * DoneCyc + 6; c++) begin
         tick();
         interrupt = (c <= 1) || (c == 3) || (c == 5) || (c == 7);
         exp_ack  = (c == 1) || (c == DoneCyc + 2);
         exp_done = (c == DoneCyc) || (c == 2 * DoneCyc + 1);
         n_checks++;
         if ({interrupt_ack, done} !== {exp_ack, exp_done}) begin
            n_fail++;
            $display("FAIL pending_cyc%0d: ack/done got %b, required %b", c,
                     {interrupt_ack, done}, {exp_ack, exp_done});
         end
         if (c == 10) begin
            n_checks++;
            if (miss_cnt !== base + 8'd2) begin
               n_fail++;
               $display("FAIL pending_miss: got %0d, required %0d", miss_cnt, base + 8'd2);
            end
         end
      end
      n_checks++;
      if (busy !== 1'b0 || miss_cnt !== base + 8'd2) begin
         n_fail++;
         $display("FAIL pending_end: busy %b miss %0d, required busy 0 miss %0d", busy, miss_cnt,
                  base + 8'd2);
      end
   endtask

   task automatic test_enable();
      bit seen_done;
      enable    = 1'b0;
      interrupt = 1'b1;
      cmd_in    = 8'h5A;
      resp[3]   = 8'h10;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) interrupt = 1'b0;
         n_checks++;
         if (interrupt_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_hold_cyc%0d: ack %b busy %b, required 0 0", c, interrupt_ack,
                     busy);
         end
      end
      push_txn(8'h10, 8'h5A);
      enable = 1'b1;
      tick();
      n_checks++;
      if (interrupt_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_ack: got %b, required 1", interrupt_ack);
      end
      seen_done = 1'b0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         tick();
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_checks++;
      if (!seen_done) begin
         n_fail++;
         $display("FAIL enable_done: done not seen within 40 cycles, required within budget");
      end
      tick();
   endtask

   task automatic test_reset_mid();
      resp[3]   = 8'h40;
      cmd_in    = 8'hA5;
      interrupt = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 2) interrupt = 1'b0;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({busy, done, interrupt_ack, write_strobe, read_strobe} !== 5'b0) begin
         n_fail++;
         $display("FAIL resetmid_ctrl: got %b, required 00000",
                  {busy, done, interrupt_ack, write_strobe, read_strobe});
      end
      n_checks++;
      if ({port_id, out_port, locx, locy, botinfo, sensors, miss_cnt} !== 56'h0) begin
         n_fail++;
         $display("FAIL resetmid_regs: got %h, required 0",
                  {port_id, out_port, locx, locy, botinfo, sensors, miss_cnt});
      end
      for (int c = 0; c < 20; c++) tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL resetmid_restart: busy got %b, required 0", busy);
      end
   endtask

   initial begin
      reset     = 1'b1;
      interrupt = 1'b0;
      enable    = 1'b1;
      cmd_in    = 8'h00;
      resp[0]   = 8'h00;
      resp[1]   = 8'h00;
      resp[2]   = 8'h00;
      resp[3]   = 8'h00;
      test_reset();
      test_txn("basic", 8'h40, 8'hA5);
      test_txn("stop", 8'h04, 8'hA5);
      test_pending();
      test_enable();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bot_port_master.md
BOT_PORT_MASTER -- requirements
Module: bot_port_master

Interface
REQ-001 Parameter PORT_MOTCTL, default 8'h09, port address written with the motor command.
REQ-002 Parameter PORT_LOCX / PORT_LOCY / PORT_BOTINFO / PORT_SENSORS, defaults 8'h0A / 8'h0B / 8'h0C / 8'h0D, port addresses read in that order.
REQ-003 Parameter PORT_LEDS, default 8'h02, LED port address.
REQ-004 Parameter STOP_MASK, default 8'h07, sensor bits that force a stop command.
REQ-005 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 port_id  output  8  port address driven to the responder.
REQ-008 out_port  output  8  write data.
REQ-009 in_port  input  8  read data from the responder.
REQ-010 write_strobe / read_strobe  output  1 each  one-cycle transfer strobes.
REQ-011 k_write_strobe  output  1  constant-write strobe, tied 0.
REQ-012 interrupt  input  1  level request from the responder.
REQ-013 interrupt_ack  output  1  one-cycle acknowledge.
REQ-014 enable  input  1  permits new transactions to start.
REQ-015 cmd_in  input  8  motor command to issue when not stopped.
REQ-016 locx / locy / botinfo / sensors  output  8 each  last captured register values.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at end of a transaction.
REQ-019 miss_cnt  output  8  count of collapsed interrupt events; saturates at 255.

Function
REQ-020 States SHALL be IDLE, ACK, RD_SETUP, RD_STROBE, RD_CAPT, WR_SETUP, WR_STROBE, LED_SETUP, LED_STROBE and DONE; all bus outputs SHALL be decoded from the registered state and data registers.
REQ-021 Event = interrupt high this cycle and low the previous cycle (registered edge detect).
REQ-022 In IDLE with enable=1 and (event or pending=1): go to ACK, clear pending.
REQ-023 ACK SHALL assert interrupt_ack for exactly one cycle.
REQ-024 Read sequence, repeated for idx 0..3 (LOCX, LOCY, BOTINFO, SENSORS):
  - RD_SETUP: port_id=address, strobes low.
  - RD_STROBE: read_strobe=1, port_id held.
  - RD_CAPT: in_port captured into the idx register, port_id held.
REQ-025 Motor value = 8'h00 if (sensors_captured & STOP_MASK) != 0, else cmd_in sampled in WR_SETUP.
REQ-026 WR_SETUP drives port_id=PORT_MOTCTL and out_port=motor value; WR_STROBE asserts write_strobe=1 with both held.
REQ-027 Outside strobe states, write_strobe and read_strobe SHALL be 0; they SHALL never be high together.
REQ-028 Latency with LED writes disabled: event sampled in IDLE at cycle 0; interrupt_ack at cycle 1; MotCtl write_strobe at cycle 15; done at cycle 16; IDLE at cycle 17.
REQ-029 An event outside IDLE (including in ACK) SHALL set pending; if pending is already set, miss_cnt SHALL increment, saturating at 255.
REQ-030 When enable=0, no transaction SHALL start; a transaction already in progress SHALL complete; pending SHALL be retained.
REQ-031 Pending set at DONE SHALL start the next ACK at cycle DONE+2, passing through one IDLE cycle.

Reset
REQ-032 reset SHALL force IDLE on the next edge, including mid-transaction; strobes and ack drop in that cycle.
REQ-033 Reset values: port_id, out_port, locx, locy, botinfo, sensors and miss_cnt = 0; busy, done, interrupt_ack and the edge register = 0; pending = 0.

Configuration
REQ-034 Macro BOT_PORT_MASTER_LED_MIRROR_EN.
  - Defined: after WR_STROBE, LED_SETUP/LED_STROBE write the captured sensors value to PORT_LEDS; done moves to cycle 18.
  - Undefined: LED states are absent and WR_STROBE goes directly to DONE.

Verification
REQ-035 Interrupt 0->1 with enable=1; in_port returns 8'h11/8'h22/8'h33/8'h40 per read; cmd_in=8'hA5 -> ack at cycle 1; locx=8'h11, locy=8'h22, botinfo=8'h33, sensors=8'h40; write to port 8'h09 with data 8'hA5 at cycle 15; done at cycle 16.
REQ-036 Same sequence but sensors read 8'h04 -> MotCtl write data 8'h00.
REQ-037 Three interrupt rising edges during one transaction -> pending set, miss_cnt=2; exactly one further transaction follows, starting at DONE+2.
REQ-038 reset asserted at cycle 7 of a transaction -> next cycle busy=0, all strobes 0, all registers 0, no MotCtl write.
REQ-039 enable=0 and an interrupt edge -> no ack; enable raised 10 cycles later -> ack on the next cycle.
REQ-040 With LED_MIRROR_EN defined and sensors=8'h40 -> write to port 8'h02 with data 8'h40 at cycle 17; done at cycle 18.
